shared_nand_sched: RTL and testbench

Round-robin scheduler that shares one bitwise NAND datapath among NREQ requesters. Each requester presents an operand pair under a valid/grant handshake. The scheduler issues at most one operation per cycle into a two-stage pipeline (operand register, then result register). It returns each result tagged with the originating requester's index, with backpressure from the consumer. The block sits between the requesting logic and the gate-level NAND/flop datapath in the timing-benchmark designs.

---
 rtl/shared_nand_sched.sv | 150 +++++++++++++++
 tb/tb_shared_nand_sched.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_nand_sched.sv
// rtl/shared_nand_sched.sv - round-robin scheduler sharing one NAND datapath among NREQ requesters
module shared_nand_sched #(
    parameter int NREQ = 4,
    parameter int DW   = 1,
    parameter int TW   = 2,
    parameter int CW   = 8
) (
    input  logic               tau2015_clk,
    input  logic               tau2015_rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] op_a,
    input  logic [NREQ*DW-1:0] op_b,
    output logic [NREQ-1:0]    gnt,
    output logic               res_valid,
    output logic [DW-1:0]      res_data,
    output logic [TW-1:0]      res_tag,
    input  logic               res_ready,
    output logic [CW-1:0]      op_cnt
);

    // Round-robin pointer: index that has first claim on the next issue slot.
    logic [TW-1:0] rr_ptr_q, rr_ptr_d;

    // Stage 1: captured operand pair and the tag of its requester.
    logic          s1_v_q, s1_v_d;
    logic [DW-1:0] s1_a_q, s1_a_d;
    logic [DW-1:0] s1_b_q, s1_b_d;
    logic [TW-1:0] s1_tag_q, s1_tag_d;

    // Stage 2: the result register presented to the consumer.
    logic          s2_v_q, s2_v_d;
    logic [DW-1:0] s2_data_q, s2_data_d;
    logic [TW-1:0] s2_tag_q, s2_tag_d;

    logic [CW-1:0] cnt_q, cnt_d;

    logic          s2_free;
    logic          s1_adv;
    logic          can_issue;
    logic          gnt_any;
    logic [TW-1:0] gnt_idx;

    // Requester index k positions after base, wrapping at NREQ. base is always < NREQ.
    function automatic logic [TW-1:0] wrap_idx(input logic [TW-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return sum[TW-1:0];
    endfunction

    // Pipeline advance conditions: S2 empties or drains, S1 moves into a free S2.
    always_comb begin
        s2_free   = !s2_v_q || res_ready;
        s1_adv    = s1_v_q && s2_free;
        can_issue = !s1_v_q || s1_adv;
    end

    // Arbiter: first active requester at or after rr_ptr, ascending with wrap.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (can_issue) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!gnt_any && req[wrap_idx(rr_ptr_q, k)]) begin
                    gnt_any = 1'b1;
                    gnt_idx = wrap_idx(rr_ptr_q, k);
                end
            end
        end
    end

    // One-hot grant, forced low while reset is held so nothing is offered mid-reset.
    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = tau2015_rst_n && gnt_any && (gnt_idx == TW'(i));
        end
    end

    // Next-state for pointer, counter and both pipeline stages.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        s1_v_d    = s1_v_q;
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
        s1_tag_d  = s1_tag_q;
        s2_v_d    = s2_v_q;
        s2_data_d = s2_data_q;
        s2_tag_d  = s2_tag_q;

        // S2 first: it either takes the S1 contents or drops its valid once consumed.
        if (s1_adv) begin
            s2_v_d    = 1'b1;
            s2_data_d = ~(s1_a_q & s1_b_q);
            s2_tag_d  = s1_tag_q;
        end else if (res_ready) begin
            s2_v_d = 1'b0;
        end

        // S1 refills on a grant (which implies it is empty or advancing), else may empty.
        if (gnt_any) begin
            s1_v_d   = 1'b1;
            s1_a_d   = op_a[int'(gnt_idx)*DW +: DW];
            s1_b_d   = op_b[int'(gnt_idx)*DW +: DW];
            s1_tag_d = gnt_idx;
            cnt_d    = cnt_q + CW'(1);
            if (int'(gnt_idx) == NREQ - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_idx + TW'(1);
            end
        end else if (s1_adv) begin
            s1_v_d = 1'b0;
        end
    end

    // State registers; reset discards anything in flight.
    always_ff @(posedge tau2015_clk or negedge tau2015_rst_n) begin
        if (!tau2015_rst_n) begin
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            s1_v_q    <= 1'b0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_tag_q  <= '0;
            s2_v_q    <= 1'b0;
            s2_data_q <= '0;
            s2_tag_q  <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            s1_v_q    <= s1_v_d;
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            s1_tag_q  <= s1_tag_d;
            s2_v_q    <= s2_v_d;
            s2_data_q <= s2_data_d;
            s2_tag_q  <= s2_tag_d;
        end
    end

    assign res_valid = s2_v_q;
    assign res_data  = s2_data_q;
    assign res_tag   = s2_tag_q;
    assign op_cnt    = cnt_q;

endmodule

// File: tb/tb_shared_nand_sched.sv
// tb/tb_shared_nand_sched.sv - self-checking bench for shared_nand_sched
module tb_shared_nand_sched;

    localparam int NREQ = 4;
    localparam int DW   = 4;
    localparam int TW   = 2;
    localparam int CW   = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*DW-1:0] op_a = '0;
    logic [NREQ*DW-1:0] op_b = '0;
    logic [NREQ-1:0]    gnt;
    logic               res_valid;
    logic [DW-1:0]      res_data;
    logic [TW-1:0]      res_tag;
    logic               res_ready = 1'b1;
    logic [CW-1:0]      op_cnt;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  vary_ops = 1'b0;

    shared_nand_sched #(.NREQ(NREQ), .DW(DW), .TW(TW), .CW(CW)) dut (
        .tau2015_clk  (clk),
        .tau2015_rst_n(rst_n),
        .req          (req),
        .op_a         (op_a),
        .op_b         (op_b),
        .gnt          (gnt),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_tag      (res_tag),
        .res_ready    (res_ready),
        .op_cnt       (op_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: ordered list of in-flight results; the head may be on the output.
    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } item_t;

    item_t mq[$];
    bit    m_head_out = 1'b0;
    int    m_rr = 0;
    int    m_cnt = 0;

    function automatic int m_gnt_idx();
        int  waiting;
        bit  room;
        if (!rst_n) return -1;
        waiting = mq.size() - (m_head_out ? 1 : 0);
        room = (waiting == 0) || !m_head_out || res_ready;
        if (!room) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (req[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
        end
        return -1;
    endfunction

    // Model update at each active edge (or reset).
    initial forever begin
        int    g;
        item_t it;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_head_out = 1'b0;
            m_rr = 0;
            m_cnt = 0;
        end else begin
            g = m_gnt_idx();
            if (m_head_out && res_ready) begin
                void'(mq.pop_front());
                m_head_out = 1'b0;
            end
            if (!m_head_out && mq.size() > 0) m_head_out = 1'b1;
            if (g >= 0) begin
                it.tag  = TW'(g);
                it.data = ~(op_a[g*DW +: DW] & op_b[g*DW +: DW]);
                mq.push_back(it);
                m_rr  = (g + 1) % NREQ;
                m_cnt = (m_cnt + 1) % (1 << CW);
            end
        end
    end

    // Compare process: checks the DUT against the model every falling edge.
    initial forever begin
        int g;
        @(negedge clk);
        g = m_gnt_idx();
        chk("gnt", 32'(gnt), (g < 0) ? 32'd0 : (32'd1 << g));
        chk("res_valid", 32'(res_valid), 32'(m_head_out));
        if (m_head_out) begin
            chk("res_data", 32'(res_data), 32'(mq[0].data));
            chk("res_tag", 32'(res_tag), 32'(mq[0].tag));
        end
        chk("op_cnt", 32'(op_cnt), 32'(m_cnt));
    end

    // Advance one cycle; inputs change 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
        if (vary_ops) begin
            op_a = (NREQ*DW)'($urandom);
            op_b = (NREQ*DW)'($urandom);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  gseq[8];
        int  tags[$];
        bit  bad_gnt;

        // Reset: outputs clear and no grant even with all requests up.
        req = 4'b1111;
        tick();
        #1;
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_res_valid", 32'(res_valid), 32'd0);
        chk("reset_res_data", 32'(res_data), 32'd0);
        chk("reset_res_tag", 32'(res_tag), 32'd0);
        chk("reset_op_cnt", 32'(op_cnt), 32'd0);
        do_reset();

        // Single request.
        res_ready = 1'b1;
        op_a = 16'hFFFF;
        op_b = 16'hFFFF;
        req = 4'b0001;
        #1;
        chk("single_gnt", 32'(gnt), 32'h1);
        tick();
        req = 4'b0000;
        tick();
        #1;
        chk("single_valid", 32'(res_valid), 32'd1);
        chk("single_data", 32'(res_data), 32'h0);
        chk("single_tag", 32'(res_tag), 32'd0);
        chk("single_cnt", 32'(op_cnt), 32'd1);
        tick();

        // Round-robin fairness with random operands.
        do_reset();
        vary_ops = 1'b1;
        req = 4'b1111;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (c < 8) begin
                gseq[c] = 32'(gnt);
            end
            if (res_valid) tags.push_back(int'(res_tag));
            if (c == 8) chk("rr_cnt", 32'(op_cnt), 32'd8);
            tick();
            if (c == 7) req = 4'b0000;
        end
        for (int c = 0; c < 8; c++) begin
            chk("rr_gnt_order", 32'(gseq[c]), 32'd1 << (c % 4));
        end
        chk("rr_tag_count", 32'(tags.size()), 32'd8);
        for (int c = 0; c < 8 && c < tags.size(); c++) begin
            chk("rr_tag_order", 32'(tags[c]), 32'(c % 4));
        end
        vary_ops = 1'b0;

        // Backpressure: two issues fill the pipe, then release.
        do_reset();
        res_ready = 1'b0;
        req = 4'b1111;
        #1;
        chk("bp_gnt0", 32'(gnt), 32'h1);
        tick();
        #1;
        chk("bp_gnt1", 32'(gnt), 32'h2);
        tick();
        tick();
        tick();
        #1;
        chk("bp_stalled_gnt", 32'(gnt), 32'd0);
        chk("bp_stalled_cnt", 32'(op_cnt), 32'd2);
        chk("bp_stalled_tag", 32'(res_tag), 32'd0);
        res_ready = 1'b1;
        #1;
        chk("bp_release_gnt", 32'(gnt), 32'h4);
        chk("bp_release_valid", 32'(res_valid), 32'd1);
        tick();
        req = 4'b0000;
        #1;
        chk("bp_next_tag", 32'(res_tag), 32'd1);
        tick();
        tick();
        tick();

        // Wrap and skip.
        do_reset();
        req = 4'b0100;
        #1;
        chk("wrap_first", 32'(gnt), 32'h4);
        tick();
        req = 4'b0101;
        bad_gnt = 1'b0;
        #1;
        chk("wrap_to0", 32'(gnt), 32'h1);
        bad_gnt |= gnt[1] | gnt[3];
        tick();
        #1;
        chk("wrap_to2", 32'(gnt), 32'h4);
        bad_gnt |= gnt[1] | gnt[3];
        tick();
        #1;
        chk("wrap_to0_again", 32'(gnt), 32'h1);
        bad_gnt |= gnt[1] | gnt[3];
        chk("wrap_no_idle_grant", 32'(bad_gnt), 32'd0);
        tick();
        req = 4'b0000;
        tick();
        tick();

        // Datapath values, checking operand selection by requester.
        do_reset();
        op_a = 16'h3A5C;
        op_b = 16'h6F0A;
        req = 4'b0001;
        tick();
        req = 4'b1000;
        tick();
        req = 4'b0000;
        #1;
        chk("dp_req0_data", 32'(res_data), 32'h7);
        chk("dp_req0_tag", 32'(res_tag), 32'd0);
        tick();
        #1;
        chk("dp_req3_data", 32'(res_data), 32'hD);
        chk("dp_req3_tag", 32'(res_tag), 32'd3);
        tick();

        // Counter wrap.
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 255; c++) tick();
        #1;
        chk("cnt_255", 32'(op_cnt), 32'd255);
        tick();
        #1;
        chk("cnt_wrap", 32'(op_cnt), 32'd0);
        req = 4'b0000;
        tick();
        tick();
        tick();

        // Reset with both stages full.
        do_reset();
        res_ready = 1'b0;
        req = 4'b1111;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(res_valid), 32'd0);
        chk("mrst_gnt", 32'(gnt), 32'd0);
        chk("mrst_cnt", 32'(op_cnt), 32'd0);
        req = 4'b1000;
        res_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        #1;
        chk("mrst_first_gnt", 32'(gnt), 32'h8);
        tick();
        req = 4'b0000;
        #1;
        chk("mrst_cnt_after", 32'(op_cnt), 32'd1);
        tick();
        tick();
        tick();

        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
